// File: rtl/alu_issue.sv
// Multi-cycle MIPS ALU issue stage: accepts one instruction, decodes it against
// a 32x32 register file, drives an external ALU, and retires via writeback.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  ALU_OP,
  input  logic [31:0] F,
  input  logic        ZF,
  input  logic        OF,
  output logic        done,
  output logic        ill,
  output logic        trap,
  output logic        zf_q,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, DEC, EXE, WB} state_t;

  state_t      state;
  logic [31:0] regs [32];
  logic [31:0] ir;

  logic [4:0]  dst_q;
  logic        legal_q;
  logic        arith_q;
  logic [31:0] f_q;
  logic        zf_c;
  logic        of_c;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [4:0]  rd_a;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [2:0]  dec_op;
  logic [4:0]  dec_dst;
  logic        dec_legal;
  logic        dec_arith;

  assign opcode = ir[31:26];
  assign rs_a   = ir[25:21];
  assign rt_a   = ir[20:16];
  assign rd_a   = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

  assign rs_val = (rs_a == 5'd0) ? '0 : regs[rs_a];
  assign rt_val = (rt_a == 5'd0) ? '0 : regs[rt_a];

  assign inst_ready = (state == IDLE);
  assign dbg_data   = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  always_comb begin
    dec_a     = rs_val;
    dec_b     = rt_val;
    dec_op    = 3'd0;
    dec_dst   = '0;
    dec_legal = 1'b1;
    dec_arith = 1'b0;
    case (opcode)
      6'h00: begin
        dec_dst = rd_a;
        case (funct)
          6'h24: dec_op = 3'd0;
          6'h25: dec_op = 3'd1;
          6'h26: dec_op = 3'd2;
          6'h27: dec_op = 3'd3;
          6'h20: begin dec_op = 3'd4; dec_arith = 1'b1; end
          6'h22: begin dec_op = 3'd5; dec_arith = 1'b1; end
          6'h2A: dec_op = 3'd6;
          6'h04: dec_op = 3'd7;
          6'h00: begin dec_op = 3'd7; dec_a = {27'b0, shamt}; end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_op = 3'd4; dec_b = {{16{imm[15]}}, imm}; dec_dst = rt_a; dec_arith = 1'b1; end
      6'h0A: begin dec_op = 3'd6; dec_b = {{16{imm[15]}}, imm}; dec_dst = rt_a; end
      6'h0C: begin dec_op = 3'd0; dec_b = {16'b0, imm}; dec_dst = rt_a; end
      6'h0D: begin dec_op = 3'd1; dec_b = {16'b0, imm}; dec_dst = rt_a; end
      6'h0E: begin dec_op = 3'd2; dec_b = {16'b0, imm}; dec_dst = rt_a; end
      default: dec_legal = 1'b0;
    endcase
    // Illegal encodings present a quiet all-zero operation to the ALU.
    if (!dec_legal) begin
      dec_a     = '0;
      dec_b     = '0;
      dec_op    = 3'd0;
      dec_dst   = '0;
      dec_arith = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      regs    <= '{default: '0};
      ir      <= '0;
      A       <= '0;
      B       <= '0;
      ALU_OP  <= '0;
      done    <= 1'b0;
      ill     <= 1'b0;
      trap    <= 1'b0;
      zf_q    <= 1'b0;
      dst_q   <= '0;
      legal_q <= 1'b0;
      arith_q <= 1'b0;
      f_q     <= '0;
      zf_c    <= 1'b0;
      of_c    <= 1'b0;
    end else begin
      done <= 1'b0;
      ill  <= 1'b0;
      trap <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_valid) begin
            ir    <= inst;
            state <= DEC;
          end
        end
        DEC: begin
          A       <= dec_a;
          B       <= dec_b;
          ALU_OP  <= dec_op;
          dst_q   <= dec_dst;
          legal_q <= dec_legal;
          arith_q <= dec_arith;
          state   <= EXE;
        end
        EXE: begin
          f_q   <= F;
          zf_c  <= ZF;
          of_c  <= OF;
          // WB-cycle pulses are registered here so they line up with done.
          done  <= 1'b1;
          ill   <= !legal_q;
          trap  <= legal_q && arith_q && OF;
          state <= WB;
        end
        WB: begin
          if (legal_q) begin
            zf_q <= zf_c;
            if (!(arith_q && of_c) && (dst_q != 5'd0))
              regs[dst_q] <= f_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
